// File: rtl/tlul_tsen_responder_pkg.sv
// Shared types for the temperature-sensor TL-UL responder: bus structs, register map, FSM states.
package tlul_tsen_responder_pkg;

  localparam int TL_AW          = 32;
  localparam int TL_DW          = 32;
  localparam int TL_SRCW        = 8;
  localparam int BLOCK_AW       = 12;
  localparam int DATA_W_DEFAULT = 16;

  typedef struct packed {
    logic               a_valid;
    logic [2:0]         a_opcode;
    logic [2:0]         a_param;
    logic [1:0]         a_size;
    logic [TL_SRCW-1:0] a_source;
    logic [TL_AW-1:0]   a_address;
    logic [3:0]         a_mask;
    logic [TL_DW-1:0]   a_data;
    logic               d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic               d_valid;
    logic [2:0]         d_opcode;
    logic [2:0]         d_param;
    logic [1:0]         d_size;
    logic [TL_SRCW-1:0] d_source;
    logic               d_sink;
    logic [TL_DW-1:0]   d_data;
    logic               d_error;
    logic               a_ready;
  } tl_d2h_t;

  localparam logic [2:0] OP_PUT_FULL    = 3'h0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'h1;
  localparam logic [2:0] OP_GET         = 3'h4;
  localparam logic [2:0] OP_ACK         = 3'h0;
  localparam logic [2:0] OP_ACK_DATA    = 3'h1;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_TIMEOUT = 2'd3;

  localparam int CTRL_START     = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_TIMEOUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENABLE  = 2'd1,
    ST_CONVERT = 2'd2
  } conv_state_e;

endpackage

// File: rtl/tlul_tsen_responder_if.sv
// TL-UL request/response pair between the peripheral crossbar and the sensor responder.
interface tlul_tsen_responder_if;
  import tlul_tsen_responder_pkg::*;

  tl_h2d_t tl_i;
  tl_d2h_t tl_o;

  modport master (output tl_i, input tl_o);
  modport slave  (input tl_i, output tl_o);
endinterface

// File: rtl/tlul_tsen_responder_conv_fsm.sv
// Sensor sequencer: enable, settle, pulse start, then wait for done or timeout.
//   state      | meaning
//   ST_IDLE    | sensor off, waiting for a START request
//   ST_ENABLE  | sensor powered, counting settle cycles
//   ST_CONVERT | start pulsed, waiting for done strobe or timeout
module tlul_tsen_responder_conv_fsm
  import tlul_tsen_responder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic             tsen_done_i,
  output logic             busy_o,
  output logic             tsen_en_o,
  output logic             tsen_start_o,
  output logic             done_evt_o,
  output logic             timeout_evt_o
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  conv_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tmo_limit;
  logic             tsen_en_q;
  logic             tsen_start_q;

  // A programmed timeout of 0 behaves like 1; >= keeps a lowered live value from being overrun.
  always_comb begin
    tmo_limit = (timeout_i == '0) ? '0 : timeout_i - CNT_W'(1);
  end

  assign done_evt_o    = (state_q == ST_CONVERT) && tsen_done_i;
  assign timeout_evt_o = (state_q == ST_CONVERT) && !tsen_done_i && (cnt_q >= tmo_limit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tsen_en_q    <= 1'b0;
      tsen_start_q <= 1'b0;
    end else begin
      tsen_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_ENABLE;
            cnt_q     <= '0;
            tsen_en_q <= 1'b1;
          end
        end
        ST_ENABLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q      <= ST_CONVERT;
            tsen_start_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          if (done_evt_o || timeout_evt_o) begin
            state_q   <= ST_IDLE;
            tsen_en_q <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          tsen_en_q <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign busy_o       = tsen_en_q;
  assign tsen_en_o    = tsen_en_q;
  assign tsen_start_o = tsen_start_q;

endmodule

// File: rtl/tlul_tsen_responder.sv
// TL-UL device endpoint for the temperature sensor: register decode, single-entry response buffer,
// and the conversion sequencer.
module tlul_tsen_responder
  import tlul_tsen_responder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_RST   = 1024,
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int CNT_W         = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tlul_tsen_responder_if.slave  tl,
  output logic                  tsen_en_o,
  output logic                  tsen_start_o,
  input  logic                  tsen_done_i,
  input  logic [DATA_W-1:0]     tsen_data_i,
  output logic                  irq_o
);

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  logic               rsp_valid_q, rsp_valid_d;
  logic [2:0]         rsp_op_q, rsp_op_d;
  logic [1:0]         rsp_size_q, rsp_size_d;
  logic [TL_SRCW-1:0] rsp_source_q, rsp_source_d;
  logic [TL_DW-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               tmo_flag_q, tmo_flag_d;
  logic [CNT_W-1:0]   tmo_cfg_q, tmo_cfg_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               a_ready, accept, is_get, is_put, req_err, wr_ok, start_req;
  logic [1:0]         reg_sel;
  logic [TL_DW-1:0]   rdata;
  logic               busy, done_evt, timeout_evt;

  assign h2d    = tl.tl_i;
  assign tl.tl_o = d2h;

  always_comb begin
    a_ready   = !rsp_valid_q || h2d.d_ready;
    accept    = h2d.a_valid && a_ready;
    reg_sel   = h2d.a_address[3:2];
    is_get    = (h2d.a_opcode == OP_GET);
    is_put    = (h2d.a_opcode == OP_PUT_FULL) || (h2d.a_opcode == OP_PUT_PARTIAL);
    req_err   = (|h2d.a_address[BLOCK_AW-1:4]) || !(is_get || is_put) ||
                (is_put && ((h2d.a_mask != 4'hF) || (reg_sel == REG_DATA) ||
                            ((reg_sel == REG_STATUS) && h2d.a_data[STATUS_BUSY])));
    wr_ok     = accept && is_put && !req_err;
    start_req = wr_ok && (reg_sel == REG_CTRL) && h2d.a_data[CTRL_START];
    rdata     = '0;
    if (is_get && !req_err) begin
      case (reg_sel)
        REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
        REG_STATUS: begin
          rdata[STATUS_BUSY]    = busy;
          rdata[STATUS_DONE]    = done_q;
          rdata[STATUS_TIMEOUT] = tmo_flag_q;
        end
        REG_DATA:   rdata[DATA_W-1:0] = data_q;
        default:    rdata[CNT_W-1:0]  = tmo_cfg_q;
      endcase
    end
  end

  // Hardware set of the sticky flags beats a simultaneous write-1-to-clear.
  always_comb begin
    irq_en_d   = irq_en_q;
    tmo_cfg_d  = tmo_cfg_q;
    done_d     = done_q;
    tmo_flag_d = tmo_flag_q;
    data_d     = data_q;
    if (wr_ok && (reg_sel == REG_CTRL))    irq_en_d  = h2d.a_data[CTRL_IRQ_EN];
    if (wr_ok && (reg_sel == REG_TIMEOUT)) tmo_cfg_d = h2d.a_data[CNT_W-1:0];
    if (wr_ok && (reg_sel == REG_STATUS)) begin
      if (h2d.a_data[STATUS_DONE])    done_d     = 1'b0;
      if (h2d.a_data[STATUS_TIMEOUT]) tmo_flag_d = 1'b0;
    end
    if (done_evt) begin
      done_d = 1'b1;
      data_d = tsen_data_i;
    end
    if (timeout_evt) tmo_flag_d = 1'b1;
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_size_d   = rsp_size_q;
    rsp_source_d = rsp_source_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_op_d     = is_get ? OP_ACK_DATA : OP_ACK;
      rsp_size_d   = h2d.a_size;
      rsp_source_d = h2d.a_source;
      rsp_data_d   = rdata;
      rsp_err_d    = req_err;
    end else if (h2d.d_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= OP_ACK;
      rsp_size_q   <= '0;
      rsp_source_q <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      tmo_flag_q   <= 1'b0;
      tmo_cfg_q    <= CNT_W'(TIMEOUT_RST);
      data_q       <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_size_q   <= rsp_size_d;
      rsp_source_q <= rsp_source_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      tmo_flag_q   <= tmo_flag_d;
      tmo_cfg_q    <= tmo_cfg_d;
      data_q       <= data_d;
    end
  end

  tlul_tsen_responder_conv_fsm #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_conv_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_req),
    .timeout_i     (tmo_cfg_q),
    .tsen_done_i   (tsen_done_i),
    .busy_o        (busy),
    .tsen_en_o     (tsen_en_o),
    .tsen_start_o  (tsen_start_o),
    .done_evt_o    (done_evt),
    .timeout_evt_o (timeout_evt)
  );

  always_comb begin
    d2h          = '0;
    d2h.d_valid  = rsp_valid_q;
    d2h.d_opcode = rsp_op_q;
    d2h.d_size   = rsp_size_q;
    d2h.d_source = rsp_source_q;
    d2h.d_data   = rsp_data_q;
    d2h.d_error  = rsp_err_q;
    d2h.a_ready  = a_ready;
  end

  assign irq_o = done_q & irq_en_q;

  logic unused_h2d;
  assign unused_h2d = ^{h2d.a_param, h2d.a_address[TL_AW-1:BLOCK_AW], h2d.a_address[1:0], h2d.a_data};

endmodule
